// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the RVX10 pipeline: load-use stalls, branch squash and
// multi-cycle execute sequencing with timeout. Optional perf counters: `HAZ_PERF_EN.
module hazard_sequencer #(
    parameter int MC_TIMEOUT = 64,  // must be >= 2
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdE,
    input  logic              MemReadE,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              McDone,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McGo,
    output logic              McErr
`ifdef HAZ_PERF_EN
    ,
    output logic [PERF_W-1:0] PerfStall,
    output logic [PERF_W-1:0] PerfFlush,
    output logic [PERF_W-1:0] PerfMcErr
`endif
);

    localparam int CNT_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lw_stall;
    logic timeout_hit;
    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, flush_m;
    logic mc_go, mc_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        mc_go   = 1'b0;
        mc_err  = 1'b0;

        lw_stall    = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        timeout_hit = (cnt_q == CNT_LAST);

        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (McStartE) begin
                    // Freeze the front end and bubble M while the unit works.
                    mc_go   = 1'b1;
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    state_d = MC_WAIT;
                end else if (PCSrcE) begin
                    // A taken branch overrides any load-use stall on the wrong path.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lw_stall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MC_WAIT: begin
                cnt_d = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);
                if (McDone) begin
                    state_d = RUN;
                end else if (timeout_hit) begin
                    mc_err  = 1'b1;
                    state_d = RUN;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are held low for the whole reset window, not just after the next edge.
    assign StallF = reset_n & stall_f;
    assign StallD = reset_n & stall_d;
    assign StallE = reset_n & stall_e;
    assign FlushD = reset_n & flush_d;
    assign FlushE = reset_n & flush_e;
    assign FlushM = reset_n & flush_m;
    assign McGo   = reset_n & mc_go;
    assign McErr  = reset_n & mc_err;

`ifdef HAZ_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_W-1:0] perf_err_q,   perf_err_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_err_d   = perf_err_q;
        if (StallF && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + PERF_W'(1);
        if ((FlushD || FlushE) && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + PERF_W'(1);
        if (McErr && (perf_err_q != '1)) perf_err_d = perf_err_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_err_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_err_q   <= perf_err_d;
        end
    end

    assign PerfStall = perf_stall_q;
    assign PerfFlush = perf_flush_q;
    assign PerfMcErr = perf_err_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer with MC_TIMEOUT=4.
// Output bundle order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McGo,McErr}.
module tb_hazard_sequencer;

    localparam int PERF_W = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       MemReadE, PCSrcE, McStartE, McDone;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McGo, McErr;
`ifdef HAZ_PERF_EN
    logic [PERF_W-1:0] PerfStall, PerfFlush, PerfMcErr;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(.MC_TIMEOUT(4), .PERF_W(PERF_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Rs1D     (Rs1D),
        .Rs2D     (Rs2D),
        .RdE      (RdE),
        .MemReadE (MemReadE),
        .PCSrcE   (PCSrcE),
        .McStartE (McStartE),
        .McDone   (McDone),
        .StallF   (StallF),
        .StallD   (StallD),
        .StallE   (StallE),
        .FlushD   (FlushD),
        .FlushE   (FlushE),
        .FlushM   (FlushM),
        .McGo     (McGo),
        .McErr    (McErr)
`ifdef HAZ_PERF_EN
        ,
        .PerfStall(PerfStall),
        .PerfFlush(PerfFlush),
        .PerfMcErr(PerfMcErr)
`endif
    );

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LWSTL = 8'b1100_1000;
    localparam logic [7:0] O_BRFL  = 8'b0001_1000;
    localparam logic [7:0] O_MCGO  = 8'b1110_0110;
    localparam logic [7:0] O_MCWT  = 8'b1110_0100;
    localparam logic [7:0] O_MCERR = 8'b0000_0001;

    function automatic logic [7:0] outs();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM, McGo, McErr};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic pc, input logic ms, input logic md);
        MemReadE = mr; RdE = rd; Rs1D = r1; Rs2D = r2;
        PCSrcE = pc; McStartE = ms; McDone = md;
    endtask

    // Drive mid-cycle, check just before the next rising edge, then advance one cycle.
    task automatic cyc(input string tag, input logic [7:0] exp);
        #3;
        check_vec(tag, {24'd0, outs()}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        cyc("reset_forces_zero", O_NONE);
        cyc("reset_holds_run", O_NONE);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); cyc("loaduse_rs2", O_LWSTL);
        drive(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0); cyc("loaduse_rs1", O_LWSTL);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("loaduse_rd0", O_NONE);
        drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0); cyc("no_load", O_NONE);
        drive(1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0); cyc("load_nomatch", O_NONE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); cyc("branch", O_BRFL);
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); cyc("branch_plus_lw", O_BRFL);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cyc("mcdone_in_run", O_NONE);

        // Multi-cycle op completed by McDone at t0+3
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); cyc("mc_t0_go", O_MCGO);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); cyc("mc_t1_wait", O_MCWT);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("mc_t2_wait_nogo", O_MCWT);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cyc("mc_t3_done", O_NONE);
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0); cyc("mc_t4_run", O_LWSTL);

        // Timeout without McDone
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("to_t0_go", O_MCGO);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("to_t1", O_MCWT);
        cyc("to_t2", O_MCWT);
        cyc("to_t3", O_MCWT);
        cyc("to_t4_err", O_MCERR);
        cyc("to_t5_run", O_NONE);

        // McDone on the timeout cycle wins over McErr
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("tod_t0_go", O_MCGO);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("tod_t1", O_MCWT);
        cyc("tod_t2", O_MCWT);
        cyc("tod_t3", O_MCWT);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cyc("tod_t4_done", O_NONE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); cyc("tod_t5_run", O_BRFL);

        // Async reset in the middle of MC_WAIT
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("rst_t0_go", O_MCGO);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("rst_t1", O_MCWT);
        #1;
        check_vec("rst_t2_before", {24'd0, outs()}, {24'd0, O_MCWT});
        reset_n = 1'b0;
        #1;
        check_vec("rst_t2_async", {24'd0, outs()}, {24'd0, O_NONE});
        @(posedge clk); #2;
        reset_n = 1'b1;
        cyc("rst_release_idle", O_NONE);
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0); cyc("rst_back_in_run", O_LWSTL);

`ifdef HAZ_PERF_EN
        begin
            logic [PERF_W-1:0] s0, f0;
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            s0 = PerfStall; f0 = PerfFlush;
            drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
            repeat (3) begin @(posedge clk); #1; end
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
            repeat (2) begin @(posedge clk); #1; end
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            check_vec("perf_stall", PerfStall - s0, 32'd3);
            check_vec("perf_flush", PerfFlush - f0, 32'd5);
            check_vec("perf_mcerr", PerfMcErr, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
